disas_trace: RTL
================

DISAS_TRACE -- requirements
Module: disas_trace

Interface
REQ-001 SHALL provide parameter ABITS, default 24, address width captured per entry (legal: 16 or 24).
REQ-002 SHALL provide parameter DEPTH, default 16, FIFO entries (power of two, 2..256).
REQ-003 SHALL provide parameter WRAP, default 0, full policy (0 = drop newest, 1 = overwrite oldest).
REQ-004 SHALL provide parameter MERGE_PFX, default 1, fold A24 prefix (8'h1F) into the following entry.
REQ-005 SHALL have ports: clk input 1 system clock; RST_N input 1 reset; one clock; reset is asynchronous and active-low.
REQ-006 SHALL have ports: sync input 1 opcode-fetch cycle; RDY input 1 CPU ready; AB input ABITS bus address; DI input 8 bus read data.
REQ-007 SHALL have ports: enable input 1 capture enable; clear input 1 synchronous flush.
REQ-008 SHALL have ports: tr_valid output 1; tr_ready input 1; tr_addr output ABITS; tr_opcode output 8; tr_class output 3; tr_a24 output 1.
REQ-009 SHALL have ports: count output $clog2(DEPTH)+1 entries held; overflow output 1 sticky loss flag; stopped output 1 STP seen.

Function
REQ-010 SHALL use states IDLE and FETCH; any edge with RDY=0 leaves state and all registers unchanged, except the read side.
REQ-011 IDLE: sync=1, RDY=1, enable=1, stopped=0 -> latch AB into addr_q, go FETCH.
REQ-012 FETCH: RDY=1 -> DI is the opcode; the entry {addr_q, DI, class, a24} is pushed on that edge; state goes IDLE, or stays FETCH with addr_q<=AB when sync=1 and enable=1 on the same edge.
REQ-013 tr_class: 1 = branch (xxx1_0000 or 8'h80); 2 = flow (8'h20, 8'h40, 8'h60, 8'h4C, 8'h6C, 8'h7C); 3 = BRK 8'h00; 4 = STP 8'hDB; 5 = prefix (8'h0F, 8'h1F); 0 = other.
REQ-014 MERGE_PFX=1, opcode 8'h1F: no push; set pfx_pend and hold the prefix address in pfx_addr; a further 8'h1F keeps the first address.
REQ-015 Next non-8'h1F opcode with pfx_pend=1: push with tr_addr=pfx_addr and tr_a24=1; clear pfx_pend.
REQ-016 MERGE_PFX=0: 8'h1F is pushed as an ordinary class-5 entry with tr_a24=0.
REQ-017 Opcode 8'hDB: push the entry, then set stopped=1; no further captures until clear.
REQ-018 Pushed entries SHALL appear on tr_* with tr_valid=1 one cycle after the push edge (FIFO head, first-word fall-through).
REQ-019 Pop occurs when tr_valid=1 and tr_ready=1; tr_* SHALL hold stable while tr_valid=1 and tr_ready=0.
REQ-020 Push and pop on the same edge SHALL both occur with count unchanged, including when full.
REQ-021 Push when full without pop: WRAP=0 discards the new entry; WRAP=1 drops the oldest and stores the new; both set overflow=1.
REQ-022 count SHALL equal entries held, range 0..DEPTH; pointers wrap modulo DEPTH.
REQ-023 clear=1 (synchronous, priority over all) SHALL empty the FIFO and zero overflow, stopped and pfx_pend; it SHALL return to IDLE; a same-edge push is discarded.
REQ-024 enable=0 SHALL block new IDLE->FETCH transitions only; an in-flight FETCH completes.

Reset
REQ-025 RST_N=0 SHALL asynchronously force IDLE, pointers 0, count=0, tr_valid=0, overflow=0, stopped=0, pfx_pend=0; tr_addr, tr_opcode, tr_class and tr_a24 read 0.
REQ-026 Reset mid-FETCH SHALL abandon the capture with no entry pushed.

Verification
REQ-027 sync+RDY, AB=24'h00F000; next cycle DI=8'hA9 -> one cycle later tr_valid=1, tr_addr=24'h00F000, tr_opcode=8'hA9, tr_class=0, count=1.
REQ-028 Fetch 8'h1F at 24'h000200, then 8'hAD at 24'h000201, MERGE_PFX=1 -> single entry {24'h000200, 8'hAD, class 0, a24=1}, count=1.
REQ-029 DEPTH=4, WRAP=0, tr_ready=0, six captures -> count=4, first four entries retained, overflow=1; repeat with WRAP=1 -> entries 3..6 retained.
REQ-030 RDY=0 for 3 cycles in FETCH, then DI=8'hD0 with RDY=1 -> exactly one entry with tr_class=1; no entry pushed during the stall.
REQ-031 Capture 8'hDB, then further sync pulses -> exactly one entry with tr_class=4 and stopped=1; after clear=1, count=0, stopped=0 and capture resumes.
REQ-032 RST_N low asynchronously mid-FETCH with 2 entries held -> same cycle tr_valid=0, count=0; no stale entry after release.

Source files
------------

// File: rtl/disas_trace.sv
`default_nettype none
// ============================================================================
//  Module   : disas_trace
//  Purpose  : Opcode-fetch trace capture for a 65xx-style bus. Watches
//             sync/RDY/AB/DI, classifies each fetched opcode and queues
//             {address, opcode, class, a24} entries in a first-word
//             fall-through FIFO drained over a valid/ready port.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, RST_N        : clock, asynchronous active-low reset
//    sync, RDY, AB, DI : CPU fetch strobe, ready, address bus, read data
//    enable            : allows new captures to start
//    clear             : synchronous flush of FIFO and sticky flags
//    tr_valid/tr_ready : FIFO head handshake
//    tr_addr, tr_opcode, tr_class, tr_a24 : FIFO head entry (0 when empty)
//    count             : entries held (0..DEPTH)
//    overflow          : sticky, an entry was lost on a full FIFO
//    stopped           : STP opcode captured, capture frozen until clear
// ============================================================================
module disas_trace #(
    parameter int ABITS     = 24,
    parameter int DEPTH     = 16,
    parameter int WRAP      = 0,
    parameter int MERGE_PFX = 1
) (
    input  logic                   clk,
    input  logic                   RST_N,
    input  logic                   sync,
    input  logic                   RDY,
    input  logic [ABITS-1:0]       AB,
    input  logic [7:0]             DI,
    input  logic                   enable,
    input  logic                   clear,
    output logic                   tr_valid,
    input  logic                   tr_ready,
    output logic [ABITS-1:0]       tr_addr,
    output logic [7:0]             tr_opcode,
    output logic [2:0]             tr_class,
    output logic                   tr_a24,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   stopped
);

    localparam int         c_pw     = $clog2(DEPTH);
    localparam int         c_cw     = c_pw + 1;
    localparam int         c_ew     = ABITS + 12;
    localparam logic [7:0] c_op_pfx = 8'h1F;
    localparam logic [7:0] c_op_stp = 8'hDB;
    localparam logic       c_merge  = (MERGE_PFX != 0);
    localparam logic       c_wrap   = (WRAP != 0);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FETCH = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ABITS-1:0]   r_addr_q;
    logic [ABITS-1:0]   r_pfx_addr;
    logic               r_pfx_pend;
    logic               r_stopped;
    logic               r_overflow;
    logic [c_pw-1:0]    r_wr_ptr;
    logic [c_pw-1:0]    r_rd_ptr;
    logic [c_cw-1:0]    r_count;
    logic [c_ew-1:0]    r_mem [DEPTH];

    logic               w_load_addr;
    logic               w_push;
    logic [ABITS-1:0]   w_push_addr;
    logic               w_push_a24;
    logic               w_set_pfx;
    logic               w_clr_pfx;
    logic               w_set_stop;
    logic [2:0]         w_class;
    logic [c_ew-1:0]    w_entry;
    logic [c_ew-1:0]    w_head;
    logic               w_valid;
    logic               w_full;
    logic               w_pop;
    logic               w_wr_en;
    logic               w_rd_adv;

    function automatic logic [2:0] classify(input logic [7:0] op);
        logic [2:0] cls;
        cls = 3'd0;
        if (op[4:0] == 5'b10000 || op == 8'h80) begin
            cls = 3'd1;
        end else begin
            case (op)
                8'h20, 8'h40, 8'h60, 8'h4C, 8'h6C, 8'h7C: cls = 3'd2;
                8'h00:                                    cls = 3'd3;
                8'hDB:                                    cls = 3'd4;
                8'h0F, 8'h1F:                             cls = 3'd5;
                default:                                  cls = 3'd0;
            endcase
        end
        return cls;
    endfunction

    assign w_class = classify(DI);
    assign w_entry = {w_push_addr, DI, w_class, w_push_a24};

    // ------------------------------------------------------------------
    // Capture FSM: next state and capture strobes. Nothing moves on the
    // capture side while RDY is low.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_load_addr = 1'b0;
        w_push      = 1'b0;
        w_push_addr = r_addr_q;
        w_push_a24  = 1'b0;
        w_set_pfx   = 1'b0;
        w_clr_pfx   = 1'b0;
        w_set_stop  = 1'b0;
        if (RDY) begin
            case (r_state)
                ST_IDLE: begin
                    if (sync && enable && !r_stopped) begin
                        w_load_addr = 1'b1;
                        w_state_nxt = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (c_merge && DI == c_op_pfx) begin
                        // Repeated prefixes keep the first prefix address.
                        w_set_pfx = !r_pfx_pend;
                    end else begin
                        w_push = 1'b1;
                        if (r_pfx_pend) begin
                            w_push_addr = r_pfx_addr;
                            w_push_a24  = 1'b1;
                            w_clr_pfx   = 1'b1;
                        end
                    end
                    w_set_stop = (DI == c_op_stp);
                    // A back-to-back fetch stays in FETCH unless STP froze us.
                    if (sync && enable && !w_set_stop) begin
                        w_load_addr = 1'b1;
                        w_state_nxt = ST_FETCH;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
        end else if (clear) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            r_addr_q   <= '0;
            r_pfx_addr <= '0;
            r_pfx_pend <= 1'b0;
            r_stopped  <= 1'b0;
        end else if (clear) begin
            r_pfx_pend <= 1'b0;
            r_stopped  <= 1'b0;
        end else begin
            if (w_load_addr) begin
                r_addr_q <= AB;
            end
            if (w_set_pfx) begin
                r_pfx_pend <= 1'b1;
                r_pfx_addr <= r_addr_q;
            end else if (w_clr_pfx) begin
                r_pfx_pend <= 1'b0;
            end
            if (w_set_stop) begin
                r_stopped <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO. A push into a full FIFO is stored only when a pop frees a
    // slot on the same edge or when overwrite mode drops the oldest.
    // ------------------------------------------------------------------
    assign w_valid  = (r_count != '0);
    assign w_full   = (r_count == c_cw'(DEPTH));
    assign w_pop    = w_valid && tr_ready;
    assign w_wr_en  = w_push && (!w_full || w_pop || c_wrap);
    assign w_rd_adv = w_pop || (w_push && w_full && c_wrap);
    assign w_head   = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + c_pw'(1);
            end
            if (w_rd_adv) begin
                r_rd_ptr <= r_rd_ptr + c_pw'(1);
            end
            r_count <= r_count + c_cw'(w_wr_en) - c_cw'(w_rd_adv);
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage needs no reset: the head is masked whenever count is zero.
    always_ff @(posedge clk) begin
        if (w_wr_en && !clear) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    assign tr_valid  = w_valid;
    assign tr_addr   = w_valid ? w_head[c_ew-1:12] : '0;
    assign tr_opcode = w_valid ? w_head[11:4]      : '0;
    assign tr_class  = w_valid ? w_head[3:1]       : '0;
    assign tr_a24    = w_valid ? w_head[0]         : 1'b0;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign stopped   = r_stopped;

endmodule
`default_nettype wire
